// File: rtl/ooo_mem_arb.sv
// ooo_mem_arb: merges the core's instruction and data ports onto one shared
// memory port. Each port has a single pending slot. A fixed-priority arbiter
// (dmem first) bounds imem starvation with a saturating counter. Every
// mem_* / upstream output comes straight from a flop.

module ooo_mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          ip_valid_q, ip_valid_d;
  logic [31:0]   ip_addr_q, ip_addr_d;
  logic [3:0]    ip_rmask_q, ip_rmask_d;
  logic          dp_valid_q, dp_valid_d;
  logic [31:0]   dp_addr_q, dp_addr_d;
  logic [3:0]    dp_rmask_q, dp_rmask_d;
  logic [3:0]    dp_wmask_q, dp_wmask_d;
  logic [31:0]   dp_wdata_q, dp_wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_rmask_q, mem_rmask_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   imem_rdata_q, imem_rdata_d;
  logic [31:0]   dmem_rdata_q, dmem_rdata_d;
  logic          imem_resp_q, imem_resp_d;
  logic          dmem_resp_q, dmem_resp_d;
  logic          i_req_s, d_req_s, d_wr_s;

  assign imem_rdata = imem_rdata_q;
  assign imem_resp  = imem_resp_q;
  assign dmem_rdata = dmem_rdata_q;
  assign dmem_resp  = dmem_resp_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rmask  = mem_rmask_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_wdata  = mem_wdata_q;

  // Capture, arbitration, FSM next state and next output values.
  always_comb begin
    state_d      = state_q;
    ip_valid_d   = ip_valid_q;
    ip_addr_d    = ip_addr_q;
    ip_rmask_d   = ip_rmask_q;
    dp_valid_d   = dp_valid_q;
    dp_addr_d    = dp_addr_q;
    dp_rmask_d   = dp_rmask_q;
    dp_wmask_d   = dp_wmask_q;
    dp_wdata_d   = dp_wdata_q;
    starve_d     = starve_q;
    mem_addr_d   = mem_addr_q;
    mem_rmask_d  = mem_rmask_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_resp_d  = 1'b0;
    dmem_resp_d  = 1'b0;

    i_req_s = (imem_rmask != 4'h0);
    d_wr_s  = (dmem_wmask != 4'h0);
    d_req_s = (dmem_rmask != 4'h0) || d_wr_s;

    // A request into an occupied slot is dropped (the checker flags it).
    if (i_req_s && !ip_valid_q) begin
      ip_valid_d = 1'b1;
      ip_addr_d  = imem_addr;
      ip_rmask_d = imem_rmask;
    end else begin
      ip_valid_d = ip_valid_q;
    end

    // A request carrying both masks is a write; its read mask is dropped.
    if (d_req_s && !dp_valid_q) begin
      dp_valid_d = 1'b1;
      dp_addr_d  = dmem_addr;
      dp_rmask_d = d_wr_s ? 4'h0 : dmem_rmask;
      dp_wmask_d = dmem_wmask;
      dp_wdata_d = dmem_wdata;
    end else begin
      dp_valid_d = dp_valid_q;
    end

    // Starvation only accumulates while imem is actually waiting.
    if (!ip_valid_q) begin
      starve_d = {CW{1'b0}};
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      IDLE: begin
        if (dp_valid_q && (!ip_valid_q || (starve_q < STARVE_MAX))) begin
          state_d     = DBUSY;
          mem_addr_d  = dp_addr_q;
          mem_rmask_d = dp_rmask_q;
          mem_wmask_d = dp_wmask_q;
          mem_wdata_d = dp_wdata_q;
          if (ip_valid_q) begin
            starve_d = starve_q + CW'(1);
          end else begin
            starve_d = {CW{1'b0}};
          end
        end else if (ip_valid_q) begin
          state_d     = IBUSY;
          mem_addr_d  = ip_addr_q;
          mem_rmask_d = ip_rmask_q;
          mem_wmask_d = 4'h0;
          mem_wdata_d = 32'h0;
          starve_d    = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      IBUSY: begin
        if (mem_resp) begin
          state_d      = GAP;
          ip_valid_d   = 1'b0;
          imem_rdata_d = mem_rdata;
          imem_resp_d  = 1'b1;
          mem_rmask_d  = 4'h0;
          mem_wmask_d  = 4'h0;
        end else begin
          state_d = IBUSY;
        end
      end
      DBUSY: begin
        if (mem_resp) begin
          state_d      = GAP;
          dp_valid_d   = 1'b0;
          dmem_rdata_d = mem_rdata;
          dmem_resp_d  = 1'b1;
          mem_rmask_d  = 4'h0;
          mem_wmask_d  = 4'h0;
        end else begin
          state_d = DBUSY;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_rmask_d = 4'h0;
        mem_wmask_d = 4'h0;
      end
    endcase
  end

  // State and output registers; reset drops all pending work immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ip_valid_q   <= 1'b0;
      ip_addr_q    <= 32'h0;
      ip_rmask_q   <= 4'h0;
      dp_valid_q   <= 1'b0;
      dp_addr_q    <= 32'h0;
      dp_rmask_q   <= 4'h0;
      dp_wmask_q   <= 4'h0;
      dp_wdata_q   <= 32'h0;
      starve_q     <= {CW{1'b0}};
      mem_addr_q   <= 32'h0;
      mem_rmask_q  <= 4'h0;
      mem_wmask_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
      imem_rdata_q <= 32'h0;
      dmem_rdata_q <= 32'h0;
      imem_resp_q  <= 1'b0;
      dmem_resp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ip_valid_q   <= ip_valid_d;
      ip_addr_q    <= ip_addr_d;
      ip_rmask_q   <= ip_rmask_d;
      dp_valid_q   <= dp_valid_d;
      dp_addr_q    <= dp_addr_d;
      dp_rmask_q   <= dp_rmask_d;
      dp_wmask_q   <= dp_wmask_d;
      dp_wdata_q   <= dp_wdata_d;
      starve_q     <= starve_d;
      mem_addr_q   <= mem_addr_d;
      mem_rmask_q  <= mem_rmask_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_resp_q  <= imem_resp_d;
      dmem_resp_q  <= dmem_resp_d;
    end
  end

  ooo_mem_arb_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .imem_rmask (imem_rmask),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .ip_valid   (ip_valid_q),
    .dp_valid   (dp_valid_q),
    .imem_resp  (imem_resp_q),
    .dmem_resp  (dmem_resp_q)
  );

endmodule

// Protocol checks on the upstream ports; no functional logic.
module ooo_mem_arb_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] imem_rmask,
  input logic [3:0] dmem_rmask,
  input logic [3:0] dmem_wmask,
  input logic       ip_valid,
  input logic       dp_valid,
  input logic       imem_resp,
  input logic       dmem_resp
);

  a_imem_overrun: assert property (@(posedge clk) disable iff (rst)
    !((imem_rmask != 4'h0) && ip_valid));

  a_dmem_overrun: assert property (@(posedge clk) disable iff (rst)
    !(((dmem_rmask | dmem_wmask) != 4'h0) && dp_valid));

  a_dmem_rw_both: assert property (@(posedge clk) disable iff (rst)
    !((dmem_rmask != 4'h0) && (dmem_wmask != 4'h0)));

  a_resp_excl: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp && dmem_resp));

endmodule
